// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// fifo_wr_arbiter : round-robin burst arbiter sharing one FIFO write port
//                   among NREQ valid/ready producers.
// Revision 1.0
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int IDW       = 2,
    parameter int WIDTH     = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  fifo_write,
    output logic [WIDTH-1:0]      fifo_data,
    input  logic                  fifo_full,
    output logic [IDW-1:0]        grant_id,
    output logic                  busy
);

    localparam int              CNTW      = $clog2(BURST_MAX) + 1;
    localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(BURST_MAX - 1);
    localparam logic [IDW-1:0]  LAST_REQ  = IDW'(NREQ - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    owner_q, owner_d;
    logic [IDW-1:0]    rr_last_q, rr_last_d;
    logic [CNTW-1:0]   beat_cnt_q, beat_cnt_d;

    logic [IDW-1:0]    pick;
    logic              pick_found;
    logic              owner_valid;
    logic [WIDTH-1:0]  owner_data;

    // Round-robin pick: lowest valid index above rr_last, else lowest overall.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                pick       = IDW'(i);
                pick_found = 1'b1;
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (i > int'(rr_last_q))) begin
                pick = IDW'(i);
            end
        end
    end

    always_comb begin
        owner_valid = 1'b0;
        owner_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == IDW'(i)) begin
                owner_valid = req_valid[i];
                owner_data  = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_last_d  = rr_last_q;
        beat_cnt_d = beat_cnt_q;
        req_ready  = '0;
        fifo_write = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    owner_d    = pick;
                    beat_cnt_d = '0;
                    state_d    = OWN;
                end
            end
            OWN: begin
                for (int i = 0; i < NREQ; i++) begin
                    req_ready[i] = ~fifo_full && (owner_q == IDW'(i));
                end
                fifo_write = owner_valid & ~fifo_full;
                if (fifo_write) begin
                    beat_cnt_d = beat_cnt_q + CNTW'(1);
                end
                // A full FIFO alone never ends a burst; only a dropped valid or the last beat does.
                if ((fifo_write && (beat_cnt_q == LAST_BEAT)) || !owner_valid) begin
                    state_d    = IDLE;
                    rr_last_d  = owner_q;
                    beat_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_last_q  <= LAST_REQ;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_last_q  <= rr_last_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign fifo_data = owner_data;
    assign grant_id  = owner_q;
    assign busy      = (state_q == OWN);

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter sharing one synchronous FIFO write port (write/data_in/full, write accepted when write & ~full) among NREQ producers.
- Each producer uses a valid/ready handshake. Bus ownership is granted in bursts of up to BURST_MAX words, so consecutive words from one producer stay contiguous in the FIFO.
- Sits between producer blocks and the FIFO. The FIFO read side is untouched.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of grant_id, = ceil(log2(NREQ))
- WIDTH, 8, data word width, equal to FIFO width
- BURST_MAX, 4, max words transferred per grant (1..16)

Ports:
- clk  in  1  clock, rising edge
- clrn  in  1  asynchronous active-low reset
- req_valid  in  NREQ  bit i: requester i has a word on req_data slice i
- req_data  in  NREQ*WIDTH  requester i word at bits [i*WIDTH +: WIDTH]
- req_ready  out  NREQ  bit i: word of requester i accepted this cycle if valid
- fifo_write  out  1  to FIFO write
- fifo_data  out  WIDTH  to FIFO data_in
- fifo_full  in  1  from FIFO full
- grant_id  out  IDW  current/last owner index
- busy  out  1  high while in OWN state

Behaviour:
- Reset is clk plus clrn, asynchronous, active-low.
- Reset values:
  - state = IDLE, owner = 0, grant_id = 0, busy = 0.
  - beat_cnt = 0.
  - rr_last = NREQ-1, so requester 0 has first priority.
  - req_ready = 0 and fifo_write = 0, since these are combinational from state, which is IDLE.
- FSM, two states: IDLE, OWN.
- IDLE:
  - req_ready = 0, fifo_write = 0.
  - If any req_valid: select the first i with req_valid[i] set, searching rr_last+1, rr_last+2, ... modulo NREQ.
  - Register owner = i, beat_cnt = 0, go to OWN.
  - grant_id updates with owner.
- OWN:
  - busy = 1.
  - req_ready[owner] = ~fifo_full. All other req_ready bits = 0.
  - fifo_write = req_valid[owner] & ~fifo_full.
  - fifo_data = req_data slice of owner, combinational.
  - On a transfer (fifo_write = 1): beat_cnt increments.
  - Exit to IDLE on either:
    - a transfer with beat_cnt == BURST_MAX-1; or
    - a cycle where req_valid[owner] = 0, whether or not fifo_full is set.
  - On exit: rr_last = owner, beat_cnt = 0.
- Stall: when fifo_full = 1 and req_valid[owner] = 1, stay in OWN with beat_cnt held and no write. A full FIFO never ends a burst.
- Latency: a request in IDLE in cycle n gives a grant (OWN) in n+1. The first word can be accepted in n+1.
- Between bursts there is always exactly one IDLE cycle. No back-to-back ownership.
- A requester re-requesting after its burst gets priority again only after all other valid requesters have been served.
- fifo_write is never asserted while fifo_full = 1. The arbiter alone prevents overflow.
- fifo_data is don't-care when fifo_write = 0. The block still drives the owner's slice.
- beat_cnt width = ceil(log2(BURST_MAX))+1, so there is no wrap inside a burst.
- Reset asserted mid-burst: immediately returns to reset values. No partial-state retention. A word presented in that cycle is not written.
- Requesters must hold req_valid/req_data stable until ready. The arbiter does not check this.

Test Plan:
- Requester 2 valid for 6 consecutive words, fifo_full = 0, BURST_MAX = 4 →
  - grant_id = 2, busy.
  - 4 writes on consecutive cycles.
  - 1 IDLE cycle.
  - Re-grant to 2.
  - 2 writes, then IDLE once valid drops.
  - FIFO holds the 6 words in order.
- All 4 requesters valid continuously, each sending distinct tagged words →
  - Grant order 0, 1, 2, 3, 0, each with a 4-word burst.
  - FIFO contents grouped in blocks of 4 per requester.
- fifo_full forced high after 2 beats of a burst for 3 cycles →
  - req_ready[owner] = 0, fifo_write = 0, beat_cnt stays 2.
  - After release, exactly 2 more writes, then IDLE.
- Owner drops req_valid after 1 beat while requester 3 waits →
  - Exit to IDLE.
  - Next grant goes to 3 one cycle later.
  - Total FIFO writes = 1 plus requester 3's burst.
- clrn pulsed low mid-burst (beat 2) →
  - busy = 0, fifo_write = 0, grant_id = 0 immediately.
  - After release, requester 0 wins if valid alongside others.
- Only requester 1 valid with fifo_full = 1 for 10 cycles →
  - Stays in OWN, zero writes.
  - No overflow and no state change until full clears.
